shift_add_mult: RTL
===================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a and b are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, N bits: the multiplicand.
REQ-007 The block SHALL have port b, input, N bits: the multiplier.
REQ-008 The block SHALL have port out_valid, output, 1 bit: product is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the product.
REQ-010 The block SHALL have port product, output, 2N bits: the product a*b.

Function
REQ-011 The block SHALL use a state machine with exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE the block SHALL hold in_ready=1; in RUN and DONE it SHALL hold in_ready=0.
REQ-013 When in_valid && in_ready, the block SHALL, on that edge:
- latch a into register M;
- load P = {N'b0, b};
- clear step counter cnt;
- enter RUN.
REQ-014 Each RUN cycle SHALL perform one step:
- addend = P[0] ? M : 0;
- {cout, sum} = P[2N-1:N] + addend;
- P <= {msb, sum, P[N-1:1]};
- cnt <= cnt + 1.
REQ-015 In unsigned mode, msb in REQ-014 SHALL equal cout.
REQ-016 cnt SHALL be $clog2(N)+1 bits wide; after the step at cnt == N-1 the block SHALL enter DONE, so out_valid rises exactly N cycles after the acceptance edge.
REQ-017 In DONE the block SHALL hold out_valid=1 and product=P stable until out_ready=1, then return to IDLE on that edge.
REQ-018 out_valid SHALL be 0 in IDLE and RUN.
REQ-019 in_valid asserted outside IDLE SHALL be ignored, with no state change and no operand capture.
REQ-020 When out_ready is 1 in DONE, the block SHALL go to IDLE only; a new operand pair SHALL be accepted no earlier than the following cycle.
REQ-021 out_ready outside DONE SHALL have no effect.
REQ-022 a and b SHALL be don't-care after the acceptance edge; only M and P are used.

Reset
REQ-023 Asserting rst SHALL, asynchronously at any time including mid-RUN, force:
- state = IDLE;
- P = 0, M = 0, cnt = 0;
- out_valid = 0;
- product = 0;
- in_ready = 1.
REQ-024 After rst deasserts, the first accepted operand pair SHALL produce a correct result with no residue from an interrupted operation.

Configuration
REQ-025 The feature SHALL be controlled by the macro MULT_SIGNED_EN.
REQ-026 With MULT_SIGNED_EN defined, a, b and product SHALL be two's-complement:
- msb = P[2N-1] ^ addend_eff[N-1] ^ cout (sign-extended bit N);
- on the final step (cnt == N-1) with P[0]=1, the block SHALL subtract M, using addend_eff = ~M and carry-in = 1;
- on all other steps, addend_eff = addend and carry-in = 0.
REQ-027 Without MULT_SIGNED_EN, the block SHALL be unsigned: carry-in tied to 0, msb = cout, and no subtract logic synthesised.

Structure
REQ-028 A shared package mult_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width function/constant.
REQ-029 The N-bit add SHALL be one instance of the team's ripple adder_n (#(N), ports A, B, Cin, Sum, Cout), the only sub-module.
REQ-030 The block SHALL contain no other arithmetic.

Verification
REQ-031 Unsigned, N=8: a=13, b=11 -> out_valid 8 cycles after acceptance, product=16'd143.
REQ-032 Unsigned, N=8, max operands: a=255, b=255 -> product=16'hFE01; a=0, b=200 -> product=16'h0000.
REQ-033 MULT_SIGNED_EN, N=8:
- a=8'hFF, b=8'hFF -> product=16'h0001;
- a=8'h80, b=8'h7F -> product=16'hC080;
- a=8'h80, b=8'h80 -> product=16'h4000;
- a=8'h05, b=8'hFD -> product=16'hFFF1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE, and pulse in_valid with new operands -> product, out_valid and in_ready=0 unchanged for all 5 cycles; the new operands are not captured.
REQ-035 Reset mid-operation: assert rst at RUN step 3 -> outputs reach their reset values immediately; then 7*9 -> product=16'd63 with correct latency.
REQ-036 Back-to-back: hold in_valid and out_ready at 1 continuously -> one result per N+2 cycles, each product correct.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the step-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One extra bit so the counter can hold N itself without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/adder_n.sv
// N-bit ripple-carry adder built from explicit full-adder equations.
module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N:0] carry_s;

    // Carry ripples from bit 0 upward.
    always_comb begin
        carry_s[0] = Cin;
        for (int i = 0; i < N; i++) begin
            Sum[i]         = A[i] ^ B[i] ^ carry_s[i];
            carry_s[i + 1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
        end
    end

    assign Cout = carry_s[N];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one partial-product step per cycle.
// Define MULT_SIGNED_EN for two's-complement operands (final-step subtract).
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int CW = cnt_width(N);

    state_e           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [2*N-1:0]   p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             last_step_s;
    logic [N-1:0]     addend_s;
    logic             cin_s;
    logic [N-1:0]     sum_s;
    logic             cout_s;
    logic             msb_s;

    assign last_step_s = (cnt_q == CW'(N - 1));

    // Select the addend and carry-in for the current step.
    always_comb begin
        addend_s = {N{1'b0}};
        cin_s    = 1'b0;
`ifdef MULT_SIGNED_EN
        if (last_step_s && p_q[0]) begin
            // Sign bit of the multiplier has weight -2^(N-1): subtract M.
            addend_s = ~m_q;
            cin_s    = 1'b1;
        end else if (p_q[0]) begin
            addend_s = m_q;
            cin_s    = 1'b0;
        end else begin
            addend_s = {N{1'b0}};
            cin_s    = 1'b0;
        end
`else
        if (p_q[0]) begin
            addend_s = m_q;
        end else begin
            addend_s = {N{1'b0}};
        end
`endif
    end

    adder_n #(.N(N)) u_adder (
        .A    (p_q[2*N-1:N]),
        .B    (addend_s),
        .Cin  (cin_s),
        .Sum  (sum_s),
        .Cout (cout_s)
    );

`ifdef MULT_SIGNED_EN
    // Bit N of the sign-extended sum keeps the running partial product signed.
    assign msb_s = p_q[2*N-1] ^ addend_s[N-1] ^ cout_s;
`else
    assign msb_s = cout_s;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    p_d     = {{N{1'b0}}, b};
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                p_d   = {msb_s, sum_s, p_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_step_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and handshake output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= {N{1'b0}};
            p_q         <= {(2*N){1'b0}};
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = p_q;

endmodule
